mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory stage of the MIPS pipeline, the consumer of everything the execute stage emits. It registers the execute outputs (ALU result, destination register number, store data, memory and write-back controls), runs loads and stores against the data-memory port with a variable-latency req/ack handshake, and stalls execute while a memory access is outstanding. It hands one retired instruction per cycle to write-back, handling byte and word alignment.

## Interface
Parameters:
- `PC_LINK_OFFSET`, default 8: value added to `inst_addr_in` for link writes (`register_src_in`=10).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ex_valid` in 1: execute presents an instruction this cycle.
- `is_nop_in` in 1: bubble; it is accepted but never retired.
- `ALU_result` in 32: result, or effective address for memory ops.
- `rt_data_in` in 32: store data.
- `rd_num` in 5: destination register.
- `register_write_in` in 1: instruction writes the register file.
- `register_src_in` in 2: write-back source. 00 = ALU, 01 = memory, 10 = link, 11 is treated as ALU.
- `we_memory_in` in 1: store.
- `is_word_in` in 1: 1 = word access, 0 = byte access.
- `inst_addr_in` in 32: instruction address.
- `halted_controller_in` in 1: this is the halt instruction.
- `stall` out 1: execute must hold its outputs.
- `mem_req` out 1, `mem_we` out 1, `mem_addr` out 32, `mem_wdata` out 32, `mem_byte_en` out 4: data-memory request.
- `mem_ack` in 1, `mem_rdata` in 32: data-memory response.
- `wb_valid` out 1, `wb_we` out 1, `wb_rd` out 5, `wb_data` out 32: retire to write-back.
- `misaligned` out 1: valid with `wb_valid`.
- `halted` out 1: sticky.

## Operation
- FSM states are IDLE, REQ and HALT.
  - `stall` = (state==REQ).
  - Inputs are sampled only in IDLE.
- IDLE, when `ex_valid` & !`is_nop_in`:
  - Capture all inputs.
  - A memory op is `we_memory_in` or `register_src_in`==01.
  - Non-memory op: register the retire outputs now.
    - `wb_data` = `ALU_result`, or `inst_addr_in`+`PC_LINK_OFFSET` when src=10. The sum is 32-bit and wraps.
    - `wb_we` = `register_write_in`.
    - Stay in IDLE, or go to HALT if halted.
  - Memory op with is_word and addr[1:0]≠0: no request is issued. Retire with `wb_we`=0 and `misaligned`=1.
  - Any other memory op: go to REQ.
- REQ:
  - `mem_req`=1, `mem_addr`={addr[31:2],2'b00}, `mem_we`=store.
  - `mem_byte_en`: word = 1111; byte = 1<<addr[1:0].
  - `mem_wdata`: word = rt; byte = rt[7:0] replicated ×4.
  - All request fields stay stable until `mem_ack`.
  - In the cycle `mem_ack`=1, register the retire outputs.
    - Load word: `wb_data` = rdata.
    - Load byte: `wb_data` = rdata byte addr[1:0] (little-endian), sign-extended.
    - Store: `wb_we`=0.
  - Next state is IDLE, or HALT if halted.
- `mem_ack` outside REQ is ignored.
- HALT: `halted`=1. All further inputs are ignored, `stall`=0, and no requests are issued. Only `reset` exits HALT.
- A halt instruction retires normally (`wb_valid`=1) before `halted` rises.
- Reset (any state, including mid-REQ): state goes to IDLE. Every output is 0: `stall`, `mem_*`, `wb_*`, `misaligned`, `halted`. The pending access is abandoned.

## Timing
- Non-memory op accepted at edge N: `wb_valid`=1 during cycle N+1, for exactly one cycle.
- Throughput is one instruction per cycle.
- Memory op accepted at edge N:
  - `mem_req` and `stall` rise in cycle N+1.
  - For ack sampled at edge M: `wb_valid` is high in cycle M+1, `stall`/`mem_req` are 0 in cycle M+1, and a new op can be accepted at edge M+1.
  - Minimum load-to-retire latency is 2 cycles (ack in the first REQ cycle).
- `wb_valid` is 0 in every cycle without a retirement.
- `wb_*` hold their last values otherwise.
- `halted` rises in the cycle after the halt instruction's `wb_valid`.

## Test plan
- Reset, then ALU op (ALU_result=0x1234, rd=5, write=1) at cycle 1 → cycle 2: `wb_valid`=1, `wb_rd`=5, `wb_data`=0x1234, `stall`=0. Back-to-back ops each retire one cycle later.
- Word load from 0x100, memory acks after 3 cycles with 0xDEADBEEF:
  - `stall`/`mem_req` high for 3 cycles.
  - `mem_byte_en`=1111 and `mem_addr`=0x100 held throughout.
  - `wb_data`=0xDEADBEEF the cycle after ack.
- Byte load from 0x103 with rdata 0x80112233 → `wb_data`=0xFFFFFF80.
- Byte store of rt=0x000000AB to 0x102 → `mem_byte_en`=0100, `mem_wdata`=0xABABABAB, `mem_we`=1, `wb_we`=0.
- Word load from 0x102 → no `mem_req`; next cycle `wb_valid`=1, `misaligned`=1, `wb_we`=0.
- Reset asserted mid-REQ → the next cycle has every output 0. Link op with inst_addr=0x40 after the halt instruction → `wb_data`=0x48 is not produced. Halt op → `wb_valid`, then `halted`=1 with later inputs ignored.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MIPS memory stage: registers execute outputs, runs data-memory access, retires to write-back
//
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   ex_valid, is_nop_in     instruction presented by execute / bubble marker
//   ALU_result, rt_data_in  ALU result or effective address / store data
//   rd_num                  destination register
//   register_write_in       instruction writes the register file
//   register_src_in         write-back source: 00 ALU, 01 memory, 10 link, 11 ALU
//   we_memory_in            store
//   is_word_in              1 = word access, 0 = byte access
//   inst_addr_in            instruction address (link value base)
//   halted_controller_in    halt instruction
//   stall                   execute must hold its outputs
//   mem_req/we/addr/wdata/byte_en, mem_ack/rdata   data-memory req/ack port
//   wb_valid/we/rd/data     retirement to write-back
//   misaligned              retired access was a misaligned word (valid with wb_valid)
//   halted                  sticky halt indication

module mem_access_stage #(
    parameter logic [31:0] PC_LINK_OFFSET = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        is_nop_in,
    input  logic [31:0] ALU_result,
    input  logic [31:0] rt_data_in,
    input  logic [4:0]  rd_num,
    input  logic        register_write_in,
    input  logic [1:0]  register_src_in,
    input  logic        we_memory_in,
    input  logic        is_word_in,
    input  logic [31:0] inst_addr_in,
    input  logic        halted_controller_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        misaligned,
    output logic        halted
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HALT} state_t;

    state_t state, next_state;

    // Fields of the instruction held while its memory access is outstanding
    logic [31:0] q_addr;
    logic [31:0] q_rt;
    logic [4:0]  q_rd;
    logic        q_write;
    logic        q_store;
    logic        q_word;
    logic        q_halt;

    logic accept;
    logic is_mem_in;
    logic misalign_in;
    logic in_req;
    logic ack_done;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    assign accept      = (state == S_IDLE) && ex_valid && !is_nop_in;
    assign is_mem_in   = we_memory_in || (register_src_in == 2'b01);
    assign misalign_in = is_word_in && (ALU_result[1:0] != 2'b00);
    assign in_req      = (state == S_REQ);
    assign ack_done    = in_req && mem_ack;

    // Request fields are driven from captured state, so they stay stable until ack
    assign stall       = in_req;
    assign mem_req     = in_req;
    assign mem_we      = in_req && q_store;
    assign mem_addr    = in_req ? {q_addr[31:2], 2'b00} : 32'd0;
    assign mem_byte_en = !in_req ? 4'b0000 : (q_word ? 4'b1111 : (4'b0001 << q_addr[1:0]));
    assign mem_wdata   = !in_req ? 32'd0 : (q_word ? q_rt : {4{q_rt[7:0]}});

    // Little-endian byte lane select, sign-extended for byte loads
    always_comb begin
        load_byte = 8'd0;
        case (q_addr[1:0])
            2'd0: load_byte = mem_rdata[7:0];
            2'd1: load_byte = mem_rdata[15:8];
            2'd2: load_byte = mem_rdata[23:16];
            2'd3: load_byte = mem_rdata[31:24];
            default: load_byte = 8'd0;
        endcase
        load_data = q_word ? mem_rdata : {{24{load_byte[7]}}, load_byte};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (is_mem_in && !misalign_in) begin
                        next_state = S_REQ;
                    end else if (halted_controller_in) begin
                        next_state = S_HALT;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    next_state = q_halt ? S_HALT : S_IDLE;
                end
            end
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_addr     <= 32'd0;
            q_rt       <= 32'd0;
            q_rd       <= 5'd0;
            q_write    <= 1'b0;
            q_store    <= 1'b0;
            q_word     <= 1'b0;
            q_halt     <= 1'b0;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            misaligned <= 1'b0;
            halted     <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            // Registered from the state so it trails the halt instruction's retirement by a cycle
            halted     <= (state == S_HALT);

            if (accept) begin
                q_addr  <= ALU_result;
                q_rt    <= rt_data_in;
                q_rd    <= rd_num;
                q_write <= register_write_in;
                q_store <= we_memory_in;
                q_word  <= is_word_in;
                q_halt  <= halted_controller_in;

                if (!is_mem_in) begin
                    wb_valid <= 1'b1;
                    wb_we    <= register_write_in;
                    wb_rd    <= rd_num;
                    wb_data  <= (register_src_in == 2'b10) ? (inst_addr_in + PC_LINK_OFFSET)
                                                           : ALU_result;
                end else if (misalign_in) begin
                    wb_valid   <= 1'b1;
                    wb_we      <= 1'b0;
                    wb_rd      <= rd_num;
                    wb_data    <= ALU_result;
                    misaligned <= 1'b1;
                end
            end

            if (ack_done) begin
                wb_valid <= 1'b1;
                wb_we    <= q_write && !q_store;
                wb_rd    <= q_rd;
                wb_data  <= load_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed self-checking bench for mem_access_stage

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        is_nop_in = 1'b0;
    logic [31:0] ALU_result = 32'd0;
    logic [31:0] rt_data_in = 32'd0;
    logic [4:0]  rd_num = 5'd0;
    logic        register_write_in = 1'b0;
    logic [1:0]  register_src_in = 2'b00;
    logic        we_memory_in = 1'b0;
    logic        is_word_in = 1'b0;
    logic [31:0] inst_addr_in = 32'd0;
    logic        halted_controller_in = 1'b0;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned;
    logic        halted;

    int checks = 0;
    int errors = 0;

    mem_access_stage #(.PC_LINK_OFFSET(32'd8)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .is_nop_in(is_nop_in),
        .ALU_result(ALU_result), .rt_data_in(rt_data_in), .rd_num(rd_num),
        .register_write_in(register_write_in), .register_src_in(register_src_in),
        .we_memory_in(we_memory_in), .is_word_in(is_word_in), .inst_addr_in(inst_addr_in),
        .halted_controller_in(halted_controller_in), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_byte_en(mem_byte_en), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [31:0] alu, input logic [31:0] rt, input logic [31:0] inst,
                          input logic [4:0] rd, input logic wr, input logic [1:0] src,
                          input logic st, input logic word, input logic hlt);
        ex_valid             = 1'b1;
        is_nop_in            = 1'b0;
        ALU_result           = alu;
        rt_data_in           = rt;
        inst_addr_in         = inst;
        rd_num               = rd;
        register_write_in    = wr;
        register_src_in      = src;
        we_memory_in         = st;
        is_word_in           = word;
        halted_controller_in = hlt;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_mem_be"}, 32'(mem_byte_en), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_we"}, 32'(wb_we), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_misaligned"}, 32'(misaligned), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // ALU op then a back-to-back non-writing op
        set_op(32'h1234, 32'd0, 32'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        chk("alu1_valid", 32'(wb_valid), 32'd1);
        chk("alu1_rd", 32'(wb_rd), 32'd5);
        chk("alu1_data", wb_data, 32'h1234);
        chk("alu1_we", 32'(wb_we), 32'd1);
        chk("alu1_stall", 32'(stall), 32'd0);
        set_op(32'h55, 32'd0, 32'd0, 5'd6, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0);
        tick();
        chk("alu2_valid", 32'(wb_valid), 32'd1);
        chk("alu2_rd", 32'(wb_rd), 32'd6);
        chk("alu2_data", wb_data, 32'h55);
        chk("alu2_we", 32'(wb_we), 32'd0);

        // Bubble is not retired; wb fields hold; stray ack in IDLE ignored
        is_nop_in = 1'b1;
        mem_ack   = 1'b1;
        tick();
        chk("nop_valid", 32'(wb_valid), 32'd0);
        chk("nop_hold_data", wb_data, 32'h55);
        chk("nop_mem_req", 32'(mem_req), 32'd0);
        mem_ack   = 1'b0;
        is_nop_in = 1'b0;
        ex_valid  = 1'b0;
        tick();
        chk("idle_valid", 32'(wb_valid), 32'd0);

        // Word load from 0x100, acked in the third REQ cycle
        set_op(32'h100, 32'd0, 32'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        // Change inputs during REQ: they must be ignored
        set_op(32'h204, 32'h77, 32'd0, 5'd3, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("lw_stall", 32'(stall), 32'd1);
            chk("lw_req", 32'(mem_req), 32'd1);
            chk("lw_addr", mem_addr, 32'h100);
            chk("lw_be", 32'(mem_byte_en), 32'hF);
            chk("lw_we", 32'(mem_we), 32'd0);
            chk("lw_wb_valid", 32'(wb_valid), 32'd0);
            if (i == 2) begin
                ex_valid  = 1'b0;
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            tick();
        end
        mem_ack = 1'b0;
        chk("lw_ret_valid", 32'(wb_valid), 32'd1);
        chk("lw_ret_data", wb_data, 32'hDEADBEEF);
        chk("lw_ret_rd", 32'(wb_rd), 32'd7);
        chk("lw_ret_we", 32'(wb_we), 32'd1);
        chk("lw_ret_stall", 32'(stall), 32'd0);
        chk("lw_ret_req", 32'(mem_req), 32'd0);

        // Byte load from 0x103, minimum latency
        set_op(32'h103, 32'd0, 32'd0, 5'd8, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        chk("lb_addr", mem_addr, 32'h100);
        chk("lb_be", 32'(mem_byte_en), 32'h8);
        ex_valid  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h80112233;
        tick();
        mem_ack = 1'b0;
        chk("lb_valid", 32'(wb_valid), 32'd1);
        chk("lb_data", wb_data, 32'hFFFFFF80);

        // Byte store of 0xAB to 0x102
        set_op(32'h102, 32'h000000AB, 32'd0, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        chk("sb_be", 32'(mem_byte_en), 32'h4);
        chk("sb_wdata", mem_wdata, 32'hABABABAB);
        chk("sb_we", 32'(mem_we), 32'd1);
        chk("sb_addr", mem_addr, 32'h100);
        ex_valid = 1'b0;
        mem_ack  = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("sb_valid", 32'(wb_valid), 32'd1);
        chk("sb_wb_we", 32'(wb_we), 32'd0);

        // Misaligned word load from 0x102
        set_op(32'h102, 32'd0, 32'd0, 5'd9, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        ex_valid = 1'b0;
        chk("mis_req", 32'(mem_req), 32'd0);
        chk("mis_stall", 32'(stall), 32'd0);
        chk("mis_valid", 32'(wb_valid), 32'd1);
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_we", 32'(wb_we), 32'd0);
        tick();
        chk("mis_valid_once", 32'(wb_valid), 32'd0);

        // Reset in the middle of an outstanding word load
        set_op(32'h200, 32'd0, 32'd0, 5'd4, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        chk("rstreq_req", 32'(mem_req), 32'd1);
        ex_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check_all_zero("rstreq");
        reset = 1'b0;

        // Link op before halt: 0x80 + 8
        set_op(32'h0, 32'd0, 32'h80, 5'd31, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        chk("link_data", wb_data, 32'h88);
        chk("link_rd", 32'(wb_rd), 32'd31);

        // Halt instruction retires, then halted rises and later inputs are ignored
        set_op(32'h99, 32'd0, 32'd0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        tick();
        chk("halt_valid", 32'(wb_valid), 32'd1);
        chk("halt_data", wb_data, 32'h99);
        chk("halt_early", 32'(halted), 32'd0);
        set_op(32'h0, 32'd0, 32'h40, 5'd31, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0);
        tick();
        chk("halted_rise", 32'(halted), 32'd1);
        chk("halted_no_link_valid", 32'(wb_valid), 32'd0);
        chk("halted_no_link_data", wb_data, 32'h99);
        set_op(32'h300, 32'd0, 32'd0, 5'd2, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0);
        tick();
        chk("halted_no_req", 32'(mem_req), 32'd0);
        chk("halted_no_stall", 32'(stall), 32'd0);
        chk("halted_sticky", 32'(halted), 32'd1);
        ex_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("halt_reset", 32'(halted), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
